// File: rtl/ula_result_queue.sv
// ----------------------------------------------------------------------------
// ula_result_queue
//   Small FIFO that captures ALU results (with their carry and a computed zero
//   flag) and hands them to a data bus one entry per pop, one cycle after the
//   pop request. Sticky overflow/underflow flags record misuse.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-high reset
//   ula_result      ALU result to capture (WIDTH bits)
//   ula_carry       ALU carry captured with the result
//   grab            push request
//   store_data_bus  pop request; entry appears on the bus the next cycle
//   clear_errors    clears overflow/underflow (a same-cycle error wins)
//   bus_data        popped result, zero when bus_oe=0
//   bus_oe          bus_data valid this cycle
//   bus_zero        zero flag of the popped entry, 0 when bus_oe=0
//   bus_carry       carry flag of the popped entry, 0 when bus_oe=0
//   count           number of stored entries
//   full, empty     count==DEPTH, count==0
//   overflow        sticky: grab while full without a simultaneous pop
//   underflow       sticky: pop while empty
// ----------------------------------------------------------------------------
module ula_result_queue #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int OVERWRITE = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         ula_result,
   input  logic                     ula_carry,
   input  logic                     grab,
   input  logic                     store_data_bus,
   input  logic                     clear_errors,
   output logic [WIDTH-1:0]         bus_data,
   output logic                     bus_oe,
   output logic                     bus_zero,
   output logic                     bus_carry,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic          OVW_C   = (OVERWRITE != 0);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             carry;
   } entry_t;

   // Zero flag is computed once at capture so the pop path is a plain read.
   function automatic logic is_zero(input logic [WIDTH-1:0] value);
      return (value == {WIDTH{1'b0}});
   endfunction

   entry_t           mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             full_r;
   logic             empty_r;
   logic [WIDTH-1:0] bus_data_r;
   logic             bus_oe_r;
   logic             bus_zero_r;
   logic             bus_carry_r;
   logic             overflow_r;
   logic             underflow_r;

   logic             do_push_s;
   logic             do_pop_s;
   logic             drop_oldest_s;
   logic             ovf_event_s;
   logic             unf_event_s;
   logic [CW-1:0]    count_nxt_s;
   logic [AW-1:0]    wr_ptr_nxt_s;
   logic [AW-1:0]    rd_ptr_nxt_s;
   entry_t           head_s;
   entry_t           new_entry_s;

   assign head_s            = mem_r[rd_ptr_r];
   assign new_entry_s.result = ula_result;
   assign new_entry_s.zero   = is_zero(ula_result);
   assign new_entry_s.carry  = ula_carry;

   // Decide which operations happen this cycle and the next pointer/count.
   always_comb begin
      do_push_s     = 1'b0;
      do_pop_s      = 1'b0;
      drop_oldest_s = 1'b0;
      ovf_event_s   = 1'b0;
      unf_event_s   = 1'b0;
      count_nxt_s   = count_r;
      wr_ptr_nxt_s  = wr_ptr_r;
      rd_ptr_nxt_s  = rd_ptr_r;

      if (store_data_bus) begin
         if (empty_r) begin
            unf_event_s = 1'b1;
         end else begin
            do_pop_s = 1'b1;
         end
      end else begin
         do_pop_s = 1'b0;
      end

      if (grab) begin
         if (!full_r) begin
            do_push_s = 1'b1;
         end else if (do_pop_s) begin
            // Full with a simultaneous pop frees the head slot: no overflow.
            do_push_s = 1'b1;
         end else begin
            ovf_event_s = 1'b1;
            if (OVW_C) begin
               // Replace the oldest entry: write slot equals head slot when full.
               do_push_s     = 1'b1;
               drop_oldest_s = 1'b1;
            end else begin
               do_push_s = 1'b0;
            end
         end
      end else begin
         do_push_s = 1'b0;
      end

      if (do_push_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end

      if (do_pop_s || drop_oldest_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end

      if (do_push_s && !do_pop_s && !drop_oldest_s) begin
         count_nxt_s = count_r + CNT_ONE;
      end else if (do_pop_s && !do_push_s) begin
         count_nxt_s = count_r - CNT_ONE;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Entry storage; not reset, contents are only visible once written.
   always_ff @(posedge clock) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= new_entry_s;
      end
   end

   // Pointers, occupancy, bus outputs and sticky error flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
         full_r      <= 1'b0;
         empty_r     <= 1'b1;
         bus_data_r  <= {WIDTH{1'b0}};
         bus_oe_r    <= 1'b0;
         bus_zero_r  <= 1'b0;
         bus_carry_r <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         count_r  <= count_nxt_s;
         full_r   <= (count_nxt_s == DEPTH_C);
         empty_r  <= (count_nxt_s == {CW{1'b0}});

         bus_oe_r <= do_pop_s;
         if (do_pop_s) begin
            bus_data_r  <= head_s.result;
            bus_zero_r  <= head_s.zero;
            bus_carry_r <= head_s.carry;
         end else begin
            bus_data_r  <= {WIDTH{1'b0}};
            bus_zero_r  <= 1'b0;
            bus_carry_r <= 1'b0;
         end

         // A new error event takes priority over clear_errors.
         if (ovf_event_s) begin
            overflow_r <= 1'b1;
         end else if (clear_errors) begin
            overflow_r <= 1'b0;
         end else begin
            overflow_r <= overflow_r;
         end

         if (unf_event_s) begin
            underflow_r <= 1'b1;
         end else if (clear_errors) begin
            underflow_r <= 1'b0;
         end else begin
            underflow_r <= underflow_r;
         end
      end
   end

   assign bus_data  = bus_data_r;
   assign bus_oe    = bus_oe_r;
   assign bus_zero  = bus_zero_r;
   assign bus_carry = bus_carry_r;
   assign count     = count_r;
   assign full      = full_r;
   assign empty     = empty_r;
   assign overflow  = overflow_r;
   assign underflow = underflow_r;

endmodule

// File: tb/tb_ula_result_queue.sv
// ----------------------------------------------------------------------------
// tb_ula_result_queue
//   Directed bench: a table of per-cycle vectors for the basic push/pop/error
//   behaviour, then hand-written sequences for overwrite mode, full-queue
//   simultaneous push/pop with pointer wrap, and asynchronous reset.
//   Two instances share stimulus: dut0 (OVERWRITE=0) and dut1 (OVERWRITE=1).
// ----------------------------------------------------------------------------
module tb_ula_result_queue;

   logic       clock;
   logic       reset;
   logic [7:0] ula_result;
   logic       ula_carry;
   logic       grab;
   logic       store_data_bus;
   logic       clear_errors;

   logic [7:0] bus_data0, bus_data1;
   logic       bus_oe0, bus_oe1;
   logic       bus_zero0, bus_zero1;
   logic       bus_carry0, bus_carry1;
   logic [2:0] count0, count1;
   logic       full0, full1;
   logic       empty0, empty1;
   logic       overflow0, overflow1;
   logic       underflow0, underflow1;

   int n_checks;
   int n_fail;

   ula_result_queue #(.WIDTH(8), .DEPTH(4), .OVERWRITE(0)) dut0 (
      .clock(clock), .reset(reset), .ula_result(ula_result), .ula_carry(ula_carry),
      .grab(grab), .store_data_bus(store_data_bus), .clear_errors(clear_errors),
      .bus_data(bus_data0), .bus_oe(bus_oe0), .bus_zero(bus_zero0), .bus_carry(bus_carry0),
      .count(count0), .full(full0), .empty(empty0),
      .overflow(overflow0), .underflow(underflow0)
   );

   ula_result_queue #(.WIDTH(8), .DEPTH(4), .OVERWRITE(1)) dut1 (
      .clock(clock), .reset(reset), .ula_result(ula_result), .ula_carry(ula_carry),
      .grab(grab), .store_data_bus(store_data_bus), .clear_errors(clear_errors),
      .bus_data(bus_data1), .bus_oe(bus_oe1), .bus_zero(bus_zero1), .bus_carry(bus_carry1),
      .count(count1), .full(full1), .empty(empty1),
      .overflow(overflow1), .underflow(underflow1)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic       g;
      logic       p;
      logic       c;
      logic [7:0] res;
      logic       cy;
      logic       oe;
      logic [7:0] data;
      logic       z;
      logic       bc;
      logic [2:0] cnt;
      logic       ovf;
      logic       unf;
   } vec_t;

   localparam int NV = 24;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic g, input logic p, input logic c,
                               input logic [7:0] res, input logic cy,
                               input logic oe, input logic [7:0] data,
                               input logic z, input logic bc,
                               input logic [2:0] cnt, input logic ovf, input logic unf);
      vec_t v;
      v.g = g; v.p = p; v.c = c; v.res = res; v.cy = cy;
      v.oe = oe; v.data = data; v.z = z; v.bc = bc;
      v.cnt = cnt; v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
   task automatic step(input logic g, input logic p, input logic c,
                       input logic [7:0] res, input logic cy);
      grab           = g;
      store_data_bus = p;
      clear_errors   = c;
      ula_result     = res;
      ula_carry      = cy;
      @(posedge clock);
      #1;
      grab           = 1'b0;
      store_data_bus = 1'b0;
      clear_errors   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      reset          = 1'b1;
      grab           = 1'b0;
      store_data_bus = 1'b0;
      clear_errors   = 1'b0;
      ula_result     = 8'h00;
      ula_carry      = 1'b0;

      // Reset state
      @(posedge clock);
      #1;
      chk("rst_count",  32'(count0),     32'd0);
      chk("rst_empty",  32'(empty0),     32'd1);
      chk("rst_full",   32'(full0),      32'd0);
      chk("rst_oe",     32'(bus_oe0),    32'd0);
      chk("rst_data",   32'(bus_data0),  32'd0);
      chk("rst_ovf",    32'(overflow0),  32'd0);
      chk("rst_unf",    32'(underflow0), 32'd0);
      reset = 1'b0;

      //             g     p     c     res    cy    oe    data   z     bc    cnt   ovf   unf
      tbl[0]  = mk(1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
      tbl[1]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
      tbl[2]  = mk(1'b1, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
      tbl[3]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
      tbl[4]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
      tbl[5]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      tbl[6]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      tbl[7]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      tbl[8]  = mk(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      tbl[9]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      tbl[10] = mk(1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
      tbl[11] = mk(1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
      tbl[12] = mk(1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
      tbl[13] = mk(1'b1, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
      tbl[14] = mk(1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
      tbl[15] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
      tbl[16] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
      tbl[17] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
      tbl[18] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      tbl[19] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      tbl[20] = mk(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1);
      tbl[21] = mk(1'b1, 1'b1, 1'b0, 8'h66, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1);
      tbl[22] = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
      tbl[23] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

      for (int i = 0; i < NV; i++) begin
         step(tbl[i].g, tbl[i].p, tbl[i].c, tbl[i].res, tbl[i].cy);
         chk($sformatf("row%0d_oe", i),    32'(bus_oe0),    32'(tbl[i].oe));
         chk($sformatf("row%0d_data", i),  32'(bus_data0),  32'(tbl[i].data));
         chk($sformatf("row%0d_zero", i),  32'(bus_zero0),  32'(tbl[i].z));
         chk($sformatf("row%0d_carry", i), 32'(bus_carry0), 32'(tbl[i].bc));
         chk($sformatf("row%0d_count", i), 32'(count0),     32'(tbl[i].cnt));
         chk($sformatf("row%0d_full", i),  32'(full0),      32'(tbl[i].cnt == 3'd4));
         chk($sformatf("row%0d_empty", i), 32'(empty0),     32'(tbl[i].cnt == 3'd0));
         chk($sformatf("row%0d_ovf", i),   32'(overflow0),  32'(tbl[i].ovf));
         chk($sformatf("row%0d_unf", i),   32'(underflow0), 32'(tbl[i].unf));
      end

      // Overflow behaviour in both modes: grab 1..5 into a 4-deep queue.
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         step(1'b1, 1'b0, 1'b0, 8'(k), 1'b0);
      end
      chk("ovw0_count", 32'(count0),    32'd4);
      chk("ovw0_ovf",   32'(overflow0), 32'd1);
      chk("ovw1_count", 32'(count1),    32'd4);
      chk("ovw1_full",  32'(full1),     32'd1);
      chk("ovw1_ovf",   32'(overflow1), 32'd1);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
         chk($sformatf("ovw0_pop%0d_oe", k),   32'(bus_oe0),   32'd1);
         chk($sformatf("ovw0_pop%0d_data", k), 32'(bus_data0), 32'(k + 1));
         chk($sformatf("ovw1_pop%0d_oe", k),   32'(bus_oe1),   32'd1);
         chk($sformatf("ovw1_pop%0d_data", k), 32'(bus_data1), 32'(k + 2));
      end
      chk("ovw1_empty_end", 32'(empty1), 32'd1);

      // Full queue with simultaneous grab and pop, then pointer wrap.
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 1'b0, 8'(8'h10 + k), 1'b0);
      end
      chk("fullgp_pre_full", 32'(full0), 32'd1);
      step(1'b1, 1'b1, 1'b0, 8'hAA, 1'b0);
      chk("fullgp_oe",     32'(bus_oe0),   32'd1);
      chk("fullgp_data",   32'(bus_data0), 32'h10);
      chk("fullgp_count",  32'(count0),    32'd4);
      chk("fullgp_ovf",    32'(overflow0), 32'd0);
      chk("fullgp_data1",  32'(bus_data1), 32'h10);
      chk("fullgp_count1", 32'(count1),    32'd4);
      chk("fullgp_ovf1",   32'(overflow1), 32'd0);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
         chk($sformatf("drain%0d_data", k), 32'(bus_data0), (k == 3) ? 32'hAA : 32'(8'h11 + k));
      end
      step(1'b1, 1'b0, 1'b0, 8'hC0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b1, 1'b0, 8'(8'hB0 + k), 1'b0);
         chk($sformatf("wrap%0d_oe", k),    32'(bus_oe0),   32'd1);
         chk($sformatf("wrap%0d_data", k),  32'(bus_data0), (k == 0) ? 32'hC0 : 32'(8'hB0 + k - 1));
         chk($sformatf("wrap%0d_count", k), 32'(count0),    32'd1);
      end
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("wrap_last_data",  32'(bus_data0), 32'hB5);
      chk("wrap_last_empty", 32'(empty0),    32'd1);

      // Asynchronous reset between edges with a pop in flight.
      do_reset();
      step(1'b1, 1'b0, 1'b0, 8'h21, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h23, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("arst_pre_oe",   32'(bus_oe0), 32'd1);
      chk("arst_pre_cnt",  32'(count0),  32'd2);
      store_data_bus = 1'b1;
      #3;
      reset = 1'b1;
      #1;
      chk("arst_count", 32'(count0),     32'd0);
      chk("arst_empty", 32'(empty0),     32'd1);
      chk("arst_full",  32'(full0),      32'd0);
      chk("arst_oe",    32'(bus_oe0),    32'd0);
      chk("arst_data",  32'(bus_data0),  32'd0);
      chk("arst_zero",  32'(bus_zero0),  32'd0);
      chk("arst_carry", 32'(bus_carry0), 32'd0);
      chk("arst_ovf",   32'(overflow0),  32'd0);
      chk("arst_unf",   32'(underflow0), 32'd0);
      @(posedge clock);
      #1;
      reset          = 1'b0;
      store_data_bus = 1'b0;
      @(posedge clock);
      #1;
      chk("arst_post_oe",    32'(bus_oe0), 32'd0);
      chk("arst_post_count", 32'(count0),  32'd0);
      step(1'b1, 1'b0, 1'b0, 8'h77, 1'b1);
      chk("arst_grab_count", 32'(count0), 32'd1);
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("arst_grab_oe",    32'(bus_oe0),    32'd1);
      chk("arst_grab_data",  32'(bus_data0),  32'h77);
      chk("arst_grab_carry", 32'(bus_carry0), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
